// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the parametrised LFSR stream source.
package lfsr_pkg;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } fsm_t;

   localparam logic [31:0] TAPS_32 = 32'hA6000000;

   // One Fibonacci shift of a width-bit state carried in a 64-bit container.
   // The feedback bit enters at bit 0; bits at and above width are cleared.
   function automatic logic [63:0] lfsr_shift(input logic [63:0] s,
                                              input logic [63:0] taps,
                                              input int          width);
      logic [63:0] mask;
      logic        fb;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      fb   = ^(s & taps & mask);
      return ((s << 1) | {63'd0, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational STEP-fold of lfsr_shift: dout is din advanced STEP shifts.
module lfsr_advance
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32),
   parameter int               STEP  = 1
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Chain STEP single shifts so a whole sample advance fits in one cycle.
   always_comb begin
      dout = din;
      for (int i = 0; i < STEP; i++) begin
         dout = WIDTH'(lfsr_shift(64'(dout), 64'(TAPS), WIDTH));
      end
   end

endmodule

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR uniform-random source with ready/valid output, runtime
// reseed, STEP shifts per sample and an accepted-sample counter.
// Optional zero-state guard: define LFSR_ZERO_GUARD_EN.
//
// state | meaning
// PRIME | state freshly loaded (reset or seed); advance once, raise valid
// RUN   | out_data valid; advance and count on each accepted sample
module lfsr_stream
   import lfsr_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_32),
   parameter int               STEP         = 1,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h00000001),
   parameter int               CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_wr,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             zero_seen
);

   fsm_t             fsm, fsm_nxt;
   logic [WIDTH-1:0] state, state_nxt;
   logic [WIDTH-1:0] adv_val, adv_next, seed_eff;
   logic             valid_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fire;
   logic             advance;

   lfsr_advance #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .STEP  (STEP)
   ) u_adv (
      .din  (state),
      .dout (adv_val)
   );

   assign out_data = state;
   assign fire     = out_valid & out_ready;

`ifdef LFSR_ZERO_GUARD_EN
   // A zero state would lock the LFSR, so both entry points substitute the seed.
   assign seed_eff = (seed_in == '0) ? DEFAULT_SEED : seed_in;
   assign adv_next = (state == '0) ? DEFAULT_SEED : adv_val;

   // Sticky flag: any zero seed or zero state observed since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_seen <= 1'b0;
      end else if ((seed_wr && seed_in == '0) || (advance && state == '0)) begin
         zero_seen <= 1'b1;
      end
   end
`else
   assign seed_eff  = seed_in;
   assign adv_next  = adv_val;
   assign zero_seen = 1'b0;
`endif

   // Next-state logic: seed write wins over a fire in the same cycle.
   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state;
      valid_nxt = out_valid;
      cnt_nxt   = sample_cnt;
      advance   = 1'b0;
      if (seed_wr) begin
         state_nxt = seed_eff;
         valid_nxt = 1'b0;
         cnt_nxt   = '0;
         fsm_nxt   = PRIME;
      end else begin
         unique case (fsm)
            PRIME: begin
               advance   = 1'b1;
               state_nxt = adv_next;
               valid_nxt = 1'b1;
               fsm_nxt   = RUN;
            end
            RUN: begin
               if (fire) begin
                  advance   = 1'b1;
                  state_nxt = adv_next;
                  cnt_nxt   = sample_cnt + CNT_W'(1);
               end
            end
            default: fsm_nxt = PRIME;
         endcase
      end
   end

   // State, datapath and counter registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= PRIME;
         state      <= DEFAULT_SEED;
         out_valid  <= 1'b0;
         sample_cnt <= '0;
      end else begin
         fsm        <= fsm_nxt;
         state      <= state_nxt;
         out_valid  <= valid_nxt;
         sample_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: vector table of seeds plus
// hand-written reset, stall and collision sequences.
module tb_lfsr_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_wr;
   logic [31:0] seed_in;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic [31:0] sample_cnt;
   logic        zero_seen;
   logic [31:0] d4_data;
   logic        d4_valid;
   logic [31:0] d4_cnt;
   logic        d4_zs;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_cnt;
   logic        zs_exp;

   typedef struct {
      logic [31:0] seed;
      logic [31:0] first;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   lfsr_stream dut (
      .clk        (clk),
      .rst        (rst),
      .seed_wr    (seed_wr),
      .seed_in    (seed_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sample_cnt (sample_cnt),
      .zero_seen  (zero_seen)
   );

   lfsr_stream #(.STEP(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .seed_wr    (seed_wr),
      .seed_in    (seed_in),
      .out_data   (d4_data),
      .out_valid  (d4_valid),
      .out_ready  (out_ready),
      .sample_cnt (d4_cnt),
      .zero_seen  (d4_zs)
   );

   // Reference shift with the default taps 31,29,26,25 written out explicitly.
   function automatic logic [31:0] m_shift(input logic [31:0] x);
      return {x[30:0], x[31] ^ x[29] ^ x[26] ^ x[25]};
   endfunction

   function automatic logic [31:0] m_adv4(input logic [31:0] x);
      return m_shift(m_shift(m_shift(m_shift(x))));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop expected samples while the consumer accepts one per cycle.
   task automatic consume(input int n);
      logic [31:0] e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("run_valid", 64'(out_valid), 64'd1);
            chk("run_data", 64'(out_data), 64'(e));
            chk("run_cnt", 64'(sample_cnt), 64'(exp_cnt));
         end
         tick();
         exp_cnt = exp_cnt + 32'd1;
      end
      chk("run_cnt_end", 64'(sample_cnt), 64'(exp_cnt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] loaded;
      logic        zguard;
`ifdef LFSR_ZERO_GUARD_EN
      zguard = 1'b1;
`else
      zguard = 1'b0;
`endif
      vecs[0] = '{32'h80000000, 32'h00000001};
      vecs[1] = '{32'h80000001, 32'h00000003};
      vecs[2] = '{32'hA6000000, 32'h4C000000};
      vecs[3] = '{32'h00000001, 32'h00000002};
      vecs[4] = '{32'h00000000, zguard ? 32'h00000002 : 32'h00000000};
      zs_exp  = 1'b0;

      rst = 1'b1; seed_wr = 1'b0; seed_in = '0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'h1);
      chk("rst_cnt", 64'(sample_cnt), 64'd0);
      chk("rst_zero_seen", 64'(zero_seen), 64'd0);

      rst = 1'b0; out_ready = 1'b1;
      tick();
      chk("prime_valid", 64'(out_valid), 64'd1);
      chk("step4_first", 64'(d4_data), 64'h10);
      chk("step4_valid", 64'(d4_valid), 64'd1);
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_cnt = '0;
      consume(3);

      // Stall: data and count frozen, then a single ready pulse.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_data", 64'(out_data), 64'h10);
         chk("stall_cnt", 64'(sample_cnt), 64'd3);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pulse_data", 64'(out_data), 64'h20);
      chk("pulse_cnt", 64'(sample_cnt), 64'd4);
      tick();
      chk("pulse_hold_data", 64'(out_data), 64'h20);
      chk("pulse_hold_cnt", 64'(sample_cnt), 64'd4);
      chk("pulse_hold_valid", 64'(out_valid), 64'd1);

      // Seed table; out_ready is high at the seed edge so a fire collides.
      for (int v = 0; v < 5; v++) begin
         loaded = (zguard && vecs[v].seed == 32'h0) ? 32'h1 : vecs[v].seed;
         if (zguard && vecs[v].seed == 32'h0) zs_exp = 1'b1;
         seed_in = vecs[v].seed; seed_wr = 1'b1; out_ready = 1'b1;
         tick();
         seed_wr = 1'b0;
         chk("seed_valid_low", 64'(out_valid), 64'd0);
         chk("seed_cnt_clear", 64'(sample_cnt), 64'd0);
         chk("seed_loaded", 64'(out_data), 64'(loaded));
         tick();
         chk("seed_step4", 64'(d4_data), 64'(m_adv4(loaded)));
         exp_q.push_back(vecs[v].first);
         exp_q.push_back(m_shift(vecs[v].first));
         exp_q.push_back(m_shift(m_shift(vecs[v].first)));
         exp_cnt = '0;
         consume(3);
         chk("zero_seen", 64'(zero_seen), 64'(zs_exp));
      end

      // Reset and seed write together: reset wins, default seed used.
      rst = 1'b1; seed_wr = 1'b1; seed_in = 32'h00001234;
      tick();
      chk("rst_seed_data", 64'(out_data), 64'h1);
      chk("rst_seed_valid", 64'(out_valid), 64'd0);
      chk("rst_seed_cnt", 64'(sample_cnt), 64'd0);
      chk("rst_seed_zero_seen", 64'(zero_seen), 64'd0);
      rst = 1'b0; seed_wr = 1'b0;
      tick();
      chk("rst_seed_first", 64'(out_data), 64'h2);
      chk("rst_seed_first_valid", 64'(out_valid), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
